// File: rtl/pulse_iface_pkg.sv
// Shared definitions for the processor-to-element pulse command interface:
// default field widths, env_word field offsets and the sequencer state type.
package pulse_iface_pkg;

    localparam int DEF_ENV_ADDR_WIDTH = 10;
    localparam int DEF_AMP_WIDTH      = 16;
    localparam int DEF_FREQ_WIDTH     = 9;
    localparam int DEF_PHASE_WIDTH    = 17;
    localparam int DEF_CFG_WIDTH      = 4;

    // env_word = {2'b0, length[9:0], 2'b0, start[9:0]}
    localparam int ENV_WORD_WIDTH     = 24;
    localparam int ENV_START_LSB      = 0;
    localparam int ENV_LENGTH_LSB     = 12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pulse_param_delay.sv
// Fixed-depth shift pipeline that carries a word's valid/last flags and its
// pulse parameters so they line up with envelope memory read data.
// Payload registers only advance behind a valid word, so the output payload
// holds its last value while out_valid is low. Flush clears every stage.
module pulse_param_delay #(
    parameter int DEPTH = 3,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         flush,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic         out_last,
    output logic [W-1:0] out_data,
    output logic         any_valid
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] last_q, last_d;
    logic [W-1:0]     dat_q [DEPTH];
    logic [W-1:0]     dat_d [DEPTH];

    // Next-stage values: shift by one, or clear everything on flush.
    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        dat_d  = dat_q;
        if (flush) begin
            vld_d  = '0;
            last_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_d[i] = '0;
            end
        end else begin
            vld_d[0]  = in_valid;
            last_d[0] = in_valid & in_last;
            if (in_valid) begin
                dat_d[0] = in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i]  = vld_q[i-1];
                last_d[i] = last_q[i-1];
                if (vld_q[i-1]) begin
                    dat_d[i] = dat_q[i-1];
                end
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        vld_q  <= vld_d;
        last_q <= last_d;
        dat_q  <= dat_d;
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_last  = last_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/pulse_env_sequencer.sv
// Receiving end of the pulse command interface. Each accepted command walks
// envelope addresses from start for length words; per-word parameters are
// delayed to meet the envelope read data. One command can wait in a pending
// slot so consecutive pulses play without a gap.
module pulse_env_sequencer
    import pulse_iface_pkg::*;
#(
    parameter int ENV_ADDR_WIDTH   = DEF_ENV_ADDR_WIDTH,
    parameter int ENV_READ_LATENCY = 3,
    parameter int AMP_WIDTH        = DEF_AMP_WIDTH,
    parameter int FREQ_WIDTH       = DEF_FREQ_WIDTH,
    parameter int PHASE_WIDTH      = DEF_PHASE_WIDTH,
    parameter int CFG_WIDTH        = DEF_CFG_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      elem_reset,
    input  logic                      cstrobe,
    input  logic [CFG_WIDTH-1:0]      cfg,
    input  logic [AMP_WIDTH-1:0]      amp,
    input  logic [FREQ_WIDTH-1:0]     freq,
    input  logic [PHASE_WIDTH-1:0]    phase,
    input  logic [ENV_WORD_WIDTH-1:0] env_word,
    output logic [ENV_ADDR_WIDTH-1:0] env_addr,
    output logic                      env_addr_valid,
    output logic                      out_valid,
    output logic [CFG_WIDTH-1:0]      out_cfg,
    output logic [AMP_WIDTH-1:0]      out_amp,
    output logic [FREQ_WIDTH-1:0]     out_freq,
    output logic [PHASE_WIDTH-1:0]    out_phase,
    output logic                      out_last,
    output logic                      busy,
    output logic                      overrun
);

    localparam int AW = ENV_ADDR_WIDTH;
    localparam int PW = CFG_WIDTH + AMP_WIDTH + FREQ_WIDTH + PHASE_WIDTH;

    seq_state_e             state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [AW-1:0]          rem_q, rem_d;
    logic [CFG_WIDTH-1:0]   act_cfg_q, act_cfg_d;
    logic [AMP_WIDTH-1:0]   act_amp_q, act_amp_d;
    logic [FREQ_WIDTH-1:0]  act_freq_q, act_freq_d;
    logic [PHASE_WIDTH-1:0] act_phase_q, act_phase_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [AW-1:0]          pend_start_q, pend_start_d;
    logic [AW-1:0]          pend_len_q, pend_len_d;
    logic [CFG_WIDTH-1:0]   pend_cfg_q, pend_cfg_d;
    logic [AMP_WIDTH-1:0]   pend_amp_q, pend_amp_d;
    logic [FREQ_WIDTH-1:0]  pend_freq_q, pend_freq_d;
    logic [PHASE_WIDTH-1:0] pend_phase_q, pend_phase_d;
    logic                   overrun_q, overrun_d;

    logic                   abort;
    logic [AW-1:0]          cmd_start;
    logic [AW-1:0]          cmd_len;
    logic                   cmd_ok;
    logic                   playing;
    logic                   word_last;
    logic                   dly_any_valid;
    logic [PW-1:0]          dly_out_data;

    assign abort     = reset | elem_reset;
    assign cmd_start = env_word[ENV_START_LSB +: AW];
    assign cmd_len   = env_word[ENV_LENGTH_LSB +: AW];
    // A zero-length command carries no words, so it is treated as no command.
    assign cmd_ok    = cstrobe & (cmd_len != '0);
    assign playing   = (state_q == ST_PLAY);
    assign word_last = playing & (rem_q == AW'(1));

    // Command acceptance, address walk, pending slot and overrun tracking.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        act_cfg_d    = act_cfg_q;
        act_amp_d    = act_amp_q;
        act_freq_d   = act_freq_q;
        act_phase_d  = act_phase_q;
        pend_vld_d   = pend_vld_q;
        pend_start_d = pend_start_q;
        pend_len_d   = pend_len_q;
        pend_cfg_d   = pend_cfg_q;
        pend_amp_d   = pend_amp_q;
        pend_freq_d  = pend_freq_q;
        pend_phase_d = pend_phase_q;
        overrun_d    = overrun_q;

        if (abort) begin
            // Abort wins over any command in the same cycle.
            state_d      = ST_IDLE;
            addr_d       = '0;
            rem_d        = '0;
            act_cfg_d    = '0;
            act_amp_d    = '0;
            act_freq_d   = '0;
            act_phase_d  = '0;
            pend_vld_d   = 1'b0;
            pend_start_d = '0;
            pend_len_d   = '0;
            pend_cfg_d   = '0;
            pend_amp_d   = '0;
            pend_freq_d  = '0;
            pend_phase_d = '0;
            overrun_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_ok) begin
                        state_d     = ST_PLAY;
                        addr_d      = cmd_start;
                        rem_d       = cmd_len;
                        act_cfg_d   = cfg;
                        act_amp_d   = amp;
                        act_freq_d  = freq;
                        act_phase_d = phase;
                    end
                end
                ST_PLAY: begin
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - AW'(1);
                    if (word_last) begin
                        if (pend_vld_q) begin
                            // Pending pulse follows with no idle cycle; a
                            // command arriving now still finds the slot full.
                            addr_d      = pend_start_q;
                            rem_d       = pend_len_q;
                            act_cfg_d   = pend_cfg_q;
                            act_amp_d   = pend_amp_q;
                            act_freq_d  = pend_freq_q;
                            act_phase_d = pend_phase_q;
                            pend_vld_d  = 1'b0;
                            if (cmd_ok) begin
                                overrun_d = 1'b1;
                            end
                        end else if (cmd_ok) begin
                            // Command on the last word goes straight to active.
                            addr_d      = cmd_start;
                            rem_d       = cmd_len;
                            act_cfg_d   = cfg;
                            act_amp_d   = amp;
                            act_freq_d  = freq;
                            act_phase_d = phase;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (cmd_ok) begin
                        if (pend_vld_q) begin
                            overrun_d = 1'b1;
                        end else begin
                            pend_vld_d   = 1'b1;
                            pend_start_d = cmd_start;
                            pend_len_d   = cmd_len;
                            pend_cfg_d   = cfg;
                            pend_amp_d   = amp;
                            pend_freq_d  = freq;
                            pend_phase_d = phase;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer state registers; reset is folded into the next-state logic.
    always_ff @(posedge clk) begin
        state_q      <= state_d;
        addr_q       <= addr_d;
        rem_q        <= rem_d;
        act_cfg_q    <= act_cfg_d;
        act_amp_q    <= act_amp_d;
        act_freq_q   <= act_freq_d;
        act_phase_q  <= act_phase_d;
        pend_vld_q   <= pend_vld_d;
        pend_start_q <= pend_start_d;
        pend_len_q   <= pend_len_d;
        pend_cfg_q   <= pend_cfg_d;
        pend_amp_q   <= pend_amp_d;
        pend_freq_q  <= pend_freq_d;
        pend_phase_q <= pend_phase_d;
        overrun_q    <= overrun_d;
    end

    assign env_addr_valid = playing;
    assign env_addr       = playing ? addr_q : '0;

    pulse_param_delay #(
        .DEPTH (ENV_READ_LATENCY),
        .W     (PW)
    ) u_delay (
        .clk       (clk),
        .flush     (abort),
        .in_valid  (playing),
        .in_last   (word_last),
        .in_data   ({act_cfg_q, act_amp_q, act_freq_q, act_phase_q}),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (dly_out_data),
        .any_valid (dly_any_valid)
    );

    assign {out_cfg, out_amp, out_freq, out_phase} = dly_out_data;
    assign busy    = playing | dly_any_valid;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_pulse_env_sequencer.sv
// Directed bench for pulse_env_sequencer: single pulse, address wrap,
// back-to-back and last-word commands, overrun, zero length and abort.
module tb_pulse_env_sequencer;

    localparam int LAT = 3;

    logic        clk;
    logic        reset;
    logic        elem_reset;
    logic        cstrobe;
    logic [3:0]  cfg;
    logic [15:0] amp;
    logic [8:0]  freq;
    logic [16:0] phase;
    logic [23:0] env_word;
    logic [9:0]  env_addr;
    logic        env_addr_valid;
    logic        out_valid;
    logic [3:0]  out_cfg;
    logic [15:0] out_amp;
    logic [8:0]  out_freq;
    logic [16:0] out_phase;
    logic        out_last;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    // Per-cycle capture of DUT outputs.
    logic        cap_av   [0:31];
    logic [9:0]  cap_a    [0:31];
    logic        cap_ov   [0:31];
    logic        cap_ol   [0:31];
    logic [15:0] cap_amp  [0:31];
    logic        cap_busy [0:31];
    logic        cap_ovr  [0:31];

    // Commands / abort scheduled at a capture index.
    int          c1, c2, cr;
    logic [9:0]  s1, l1, s2, l2;
    logic [15:0] a1, a2;

    pulse_env_sequencer #(
        .ENV_ADDR_WIDTH   (10),
        .ENV_READ_LATENCY (LAT),
        .AMP_WIDTH        (16),
        .FREQ_WIDTH       (9),
        .PHASE_WIDTH      (17),
        .CFG_WIDTH        (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .elem_reset     (elem_reset),
        .cstrobe        (cstrobe),
        .cfg            (cfg),
        .amp            (amp),
        .freq           (freq),
        .phase          (phase),
        .env_word       (env_word),
        .env_addr       (env_addr),
        .env_addr_valid (env_addr_valid),
        .out_valid      (out_valid),
        .out_cfg        (out_cfg),
        .out_amp        (out_amp),
        .out_freq       (out_freq),
        .out_phase      (out_phase),
        .out_last       (out_last),
        .busy           (busy),
        .overrun        (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        c1 = -1; c2 = -1; cr = -1;
        s1 = '0; l1 = '0; a1 = '0;
        s2 = '0; l2 = '0; a2 = '0;
    endtask

    task automatic drive_cmd(input logic [9:0] s, input logic [9:0] l, input logic [15:0] a);
        cstrobe  = 1'b1;
        env_word = {2'b00, l, 2'b00, s};
        amp      = a;
        cfg      = 4'h3;
        freq     = 9'd77;
        phase    = 17'h1abcd;
    endtask

    // Garbage on the parameter inputs without a strobe must not leak through.
    task automatic scramble();
        cfg      = 4'hf;
        amp      = 16'hdead;
        freq     = 9'h1ff;
        phase    = 17'h0;
        env_word = 24'h3ff3ff;
    endtask

    task automatic start_pulse(input logic [9:0] s, input logic [9:0] l, input logic [15:0] a);
        drive_cmd(s, l, a);
        tick();
        cstrobe = 1'b0;
        scramble();
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_av[i]   = env_addr_valid;
            cap_a[i]    = env_addr;
            cap_ov[i]   = out_valid;
            cap_ol[i]   = out_last;
            cap_amp[i]  = out_amp;
            cap_busy[i] = busy;
            cap_ovr[i]  = overrun;
            if (i == c1) drive_cmd(s1, l1, a1);
            else if (i == c2) drive_cmd(s2, l2, a2);
            if (i == cr) elem_reset = 1'b1;
            tick();
            cstrobe    = 1'b0;
            elem_reset = 1'b0;
            scramble();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_cmd(10'd5, 10'd4, 16'h1111);
        repeat (3) tick();
        checks++; if (env_addr_valid !== 1'b0) begin failures++; $display("FAIL reset_av got=%b exp=0", env_addr_valid); end
        checks++; if (env_addr !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", env_addr); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_ov got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_ol got=%b exp=0", out_last); end
        checks++; if (out_amp !== 16'h0) begin failures++; $display("FAIL reset_amp got=%h exp=0", out_amp); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
        // Strobe held across reset is lost.
        reset   = 1'b0;
        cstrobe = 1'b0;
        scramble();
        tick();
        checks++; if (env_addr_valid !== 1'b0) begin failures++; $display("FAIL reset_prio_av got=%b exp=0", env_addr_valid); end
    endtask

    task automatic test_single();
        clear_sched();
        start_pulse(10'd5, 10'd4, 16'h1234);
        capture(12);
        for (int i = 0; i < 12; i++) begin
            checks++; if (cap_av[i] !== (i < 4)) begin failures++; $display("FAIL single_av[%0d] got=%b exp=%b", i, cap_av[i], (i < 4)); end
            if (i < 4) begin
                checks++; if (cap_a[i] !== 10'(5 + i)) begin failures++; $display("FAIL single_addr[%0d] got=%0d exp=%0d", i, cap_a[i], 5 + i); end
            end
            checks++; if (cap_ov[i] !== (i >= 3 && i <= 6)) begin failures++; $display("FAIL single_ov[%0d] got=%b", i, cap_ov[i]); end
            checks++; if (cap_ol[i] !== (i == 6)) begin failures++; $display("FAIL single_ol[%0d] got=%b", i, cap_ol[i]); end
            checks++; if (cap_busy[i] !== (i <= 6)) begin failures++; $display("FAIL single_busy[%0d] got=%b", i, cap_busy[i]); end
            if (i >= 3) begin
                checks++; if (cap_amp[i] !== 16'h1234) begin failures++; $display("FAIL single_amp[%0d] got=%h exp=1234", i, cap_amp[i]); end
            end
        end
        checks++; if (out_cfg !== 4'h3) begin failures++; $display("FAIL single_cfg got=%h exp=3", out_cfg); end
        checks++; if (out_freq !== 9'd77) begin failures++; $display("FAIL single_freq got=%0d exp=77", out_freq); end
        checks++; if (out_phase !== 17'h1abcd) begin failures++; $display("FAIL single_phase got=%h exp=1abcd", out_phase); end
    endtask

    task automatic test_wrap();
        clear_sched();
        start_pulse(10'd1022, 10'd4, 16'h0101);
        capture(10);
        for (int i = 0; i < 10; i++) begin
            checks++; if (cap_av[i] !== (i < 4)) begin failures++; $display("FAIL wrap_av[%0d] got=%b", i, cap_av[i]); end
            if (i < 4) begin
                checks++; if (cap_a[i] !== 10'(1022 + i)) begin failures++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, cap_a[i], 10'(1022 + i)); end
            end
            checks++; if (cap_ol[i] !== (i == 6)) begin failures++; $display("FAIL wrap_ol[%0d] got=%b", i, cap_ol[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_a [0:4];
        exp_a = '{10'd0, 10'd1, 10'd2, 10'd100, 10'd101};
        clear_sched();
        c1 = 1; s1 = 10'd100; l1 = 10'd2; a1 = 16'h00b0;
        start_pulse(10'd0, 10'd3, 16'h00a0);
        capture(10);
        for (int i = 0; i < 10; i++) begin
            checks++; if (cap_av[i] !== (i < 5)) begin failures++; $display("FAIL b2b_av[%0d] got=%b", i, cap_av[i]); end
            if (i < 5) begin
                checks++; if (cap_a[i] !== exp_a[i]) begin failures++; $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", i, cap_a[i], exp_a[i]); end
            end
            checks++; if (cap_ov[i] !== (i >= 3 && i <= 7)) begin failures++; $display("FAIL b2b_ov[%0d] got=%b", i, cap_ov[i]); end
            checks++; if (cap_ol[i] !== (i == 5 || i == 7)) begin failures++; $display("FAIL b2b_ol[%0d] got=%b", i, cap_ol[i]); end
            if (i >= 3 && i <= 5) begin
                checks++; if (cap_amp[i] !== 16'h00a0) begin failures++; $display("FAIL b2b_ampA[%0d] got=%h exp=00a0", i, cap_amp[i]); end
            end
            if (i == 6 || i == 7) begin
                checks++; if (cap_amp[i] !== 16'h00b0) begin failures++; $display("FAIL b2b_ampB[%0d] got=%h exp=00b0", i, cap_amp[i]); end
            end
        end
    endtask

    task automatic test_last_word_strobe();
        logic [9:0] exp_a [0:2];
        exp_a = '{10'd200, 10'd201, 10'd300};
        clear_sched();
        c1 = 1; s1 = 10'd300; l1 = 10'd1; a1 = 16'h00c0;
        start_pulse(10'd200, 10'd2, 16'h00d0);
        capture(8);
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_av[i] !== (i < 3)) begin failures++; $display("FAIL lastcmd_av[%0d] got=%b", i, cap_av[i]); end
            if (i < 3) begin
                checks++; if (cap_a[i] !== exp_a[i]) begin failures++; $display("FAIL lastcmd_addr[%0d] got=%0d exp=%0d", i, cap_a[i], exp_a[i]); end
            end
            checks++; if (cap_ol[i] !== (i == 4 || i == 5)) begin failures++; $display("FAIL lastcmd_ol[%0d] got=%b", i, cap_ol[i]); end
        end
        checks++; if (cap_amp[5] !== 16'h00c0) begin failures++; $display("FAIL lastcmd_amp got=%h exp=00c0", cap_amp[5]); end
    endtask

    task automatic test_overrun();
        clear_sched();
        c1 = 2; s1 = 10'd50; l1 = 10'd2; a1 = 16'h00b2;
        c2 = 4; s2 = 10'd70; l2 = 10'd2; a2 = 16'h00c3;
        start_pulse(10'd10, 10'd10, 16'h00a1);
        capture(20);
        for (int i = 0; i < 20; i++) begin
            checks++; if (cap_av[i] !== (i < 12)) begin failures++; $display("FAIL ovr_av[%0d] got=%b", i, cap_av[i]); end
            if (i < 10) begin
                checks++; if (cap_a[i] !== 10'(10 + i)) begin failures++; $display("FAIL ovr_addr[%0d] got=%0d exp=%0d", i, cap_a[i], 10 + i); end
            end else if (i < 12) begin
                checks++; if (cap_a[i] !== 10'(40 + i)) begin failures++; $display("FAIL ovr_addrB[%0d] got=%0d exp=%0d", i, cap_a[i], 40 + i); end
            end
            checks++; if (cap_ovr[i] !== (i >= 5)) begin failures++; $display("FAIL ovr_flag[%0d] got=%b exp=%b", i, cap_ovr[i], (i >= 5)); end
        end
        checks++; if (cap_amp[14] !== 16'h00b2) begin failures++; $display("FAIL ovr_ampB got=%h exp=00b2", cap_amp[14]); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_len_zero();
        clear_sched();
        start_pulse(10'd5, 10'd0, 16'h7777);
        capture(6);
        for (int i = 0; i < 6; i++) begin
            checks++; if (cap_av[i] !== 1'b0) begin failures++; $display("FAIL len0_av[%0d] got=%b exp=0", i, cap_av[i]); end
            checks++; if (cap_busy[i] !== 1'b0) begin failures++; $display("FAIL len0_busy[%0d] got=%b exp=0", i, cap_busy[i]); end
            checks++; if (cap_ovr[i] !== 1'b0) begin failures++; $display("FAIL len0_ovr[%0d] got=%b exp=0", i, cap_ovr[i]); end
        end
    endtask

    task automatic test_abort();
        clear_sched();
        cr = 2;
        start_pulse(10'd40, 10'd8, 16'h0055);
        capture(6);
        for (int i = 0; i < 6; i++) begin
            checks++; if (cap_av[i] !== (i < 3)) begin failures++; $display("FAIL abort_av[%0d] got=%b", i, cap_av[i]); end
            if (i < 3) begin
                checks++; if (cap_a[i] !== 10'(40 + i)) begin failures++; $display("FAIL abort_addr[%0d] got=%0d exp=%0d", i, cap_a[i], 40 + i); end
            end
            checks++; if (cap_ov[i] !== 1'b0) begin failures++; $display("FAIL abort_ov[%0d] got=%b exp=0", i, cap_ov[i]); end
            checks++; if (cap_busy[i] !== (i < 3)) begin failures++; $display("FAIL abort_busy[%0d] got=%b", i, cap_busy[i]); end
        end
        clear_sched();
        start_pulse(10'd60, 10'd2, 16'h0066);
        capture(8);
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_av[i] !== (i < 2)) begin failures++; $display("FAIL reprime_av[%0d] got=%b", i, cap_av[i]); end
            if (i < 2) begin
                checks++; if (cap_a[i] !== 10'(60 + i)) begin failures++; $display("FAIL reprime_addr[%0d] got=%0d exp=%0d", i, cap_a[i], 60 + i); end
            end
            checks++; if (cap_ov[i] !== (i == 3 || i == 4)) begin failures++; $display("FAIL reprime_ov[%0d] got=%b", i, cap_ov[i]); end
            checks++; if (cap_ol[i] !== (i == 4)) begin failures++; $display("FAIL reprime_ol[%0d] got=%b", i, cap_ol[i]); end
        end
        checks++; if (cap_amp[3] !== 16'h0066) begin failures++; $display("FAIL reprime_amp got=%h exp=0066", cap_amp[3]); end
    endtask

    initial begin
        reset      = 1'b1;
        elem_reset = 1'b0;
        cstrobe    = 1'b0;
        scramble();
        clear_sched();
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_last_word_strobe();
        test_overrun();
        test_len_zero();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
